// File: rtl/inst_fetch_pkg.sv
// Shared types for the byte-serial instruction fetch path and its optional cache.
// Bus widths, FSM state codes and cache index/tag helpers live here.
package inst_fetch_pkg;

  localparam int InstAddrW    = 32;
  localparam int InstW        = 32;
  localparam int ByteW        = 8;
  localparam int ICacheIndexW = 4;
  localparam int ICacheTagW   = 26;
  localparam int ICacheDepth  = 16;

  typedef logic [InstAddrW-1:0]    inst_addr_t;
  typedef logic [InstW-1:0]        inst_t;
  typedef logic [ByteW-1:0]        byte_t;
  typedef logic [ICacheIndexW-1:0] icache_index_t;
  typedef logic [ICacheTagW-1:0]   icache_tag_t;

  typedef enum logic {
    FetchIdle,
    FetchBusy
  } fetch_state_e;

  function automatic icache_index_t cacheIndex(input inst_addr_t addr);
    return addr[5:2];
  endfunction

  function automatic icache_tag_t cacheTag(input inst_addr_t addr);
    return addr[31:6];
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage request/response plus the byte-wide memory port, bundled as one interface.
// The fetch unit uses the slave view; the fetch stage/memory side uses the master view.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  inst_addr_t pc;
  logic       ce;
  inst_t      inst;
  logic       inst_valid;
  logic       stall_req;
  inst_addr_t mem_a;
  byte_t      mem_din;
  logic       mem_wr;

  modport master (
    output pc, ce, mem_din,
    input  inst, inst_valid, stall_req, mem_a, mem_wr
  );

  modport slave (
    input  pc, ce, mem_din,
    output inst, inst_valid, stall_req, mem_a, mem_wr
  );

endinterface

// File: rtl/inst_cache.sv
// 16-entry direct-mapped instruction cache, compiled only when ICACHE_EN is defined.
// Lookup is combinational; fills land on the clock edge and only for word-aligned addresses.
`ifdef ICACHE_EN
module inst_cache
  import inst_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  inst_addr_t lookup_addr_i,
  output logic       hit_o,
  output inst_t      data_o,
  input  logic       fill_en_i,
  input  inst_addr_t fill_addr_i,
  input  inst_t      fill_data_i
);

  logic [ICacheDepth-1:0] valid_q;
  icache_tag_t            tag_q  [ICacheDepth];
  inst_t                  data_q [ICacheDepth];

  icache_index_t lookupIdx;
  icache_index_t fillIdx;
  logic          doFill;

  assign lookupIdx = cacheIndex(lookup_addr_i);
  assign fillIdx   = cacheIndex(fill_addr_i);
  assign doFill    = fill_en_i && (fill_addr_i[1:0] == 2'b00);

  assign hit_o  = valid_q[lookupIdx] &&
                  (tag_q[lookupIdx] == cacheTag(lookup_addr_i)) &&
                  (lookup_addr_i[1:0] == 2'b00);
  assign data_o = data_q[lookupIdx];

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (doFill) begin
      valid_q[fillIdx] <= 1'b1;
      tag_q[fillIdx]   <= cacheTag(fill_addr_i);
      data_q[fillIdx]  <= fill_data_i;
    end
  end

endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction-fetch responder: reads four bytes little-endian from a byte-wide memory port.
// Define ICACHE_EN to add a 16-entry direct-mapped cache that answers aligned hits in one cycle.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  inst_fetch_if.slave bus
);

  fetch_state_e state_q;
  logic [2:0]   cnt_q;
  inst_addr_t   addr_q;
  inst_addr_t   memA_q;
  logic [23:0]  asm_q;
  inst_t        inst_q;
  logic         valid_q;
  logic         stall_q;
  logic         memWr_q;

  inst_addr_t   nextAddr_d;
  logic         hit;
  inst_t        hitData;

  assign nextAddr_d = addr_q + {29'd0, cnt_q} + 32'd1;

`ifdef ICACHE_EN
  logic  fillEn;
  inst_t fillData;

  assign fillEn   = (state_q == FetchBusy) && (cnt_q == 3'd4);
  assign fillData = {bus.mem_din, asm_q};

  inst_cache u_inst_cache (
    .clk           (clk),
    .rst           (rst),
    .lookup_addr_i (bus.pc),
    .hit_o         (hit),
    .data_o        (hitData),
    .fill_en_i     (fillEn),
    .fill_addr_i   (addr_q),
    .fill_data_i   (fillData)
  );
`else
  assign hit     = 1'b0;
  assign hitData = '0;
`endif

  // Memory data lags its address by one cycle, so byte lane cnt-1 is captured at count cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FetchIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      memA_q  <= '0;
      asm_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      memWr_q <= 1'b0;
    end else begin
      memWr_q <= 1'b0;
      case (state_q)
        FetchIdle: begin
          valid_q <= 1'b0;
          if (bus.ce && hit) begin
            inst_q  <= hitData;
            valid_q <= 1'b1;
          end else if (bus.ce) begin
            addr_q  <= bus.pc;
            memA_q  <= bus.pc;
            cnt_q   <= '0;
            stall_q <= 1'b1;
            state_q <= FetchBusy;
          end
        end
        FetchBusy: begin
          case (cnt_q)
            3'd1:    asm_q[7:0]   <= bus.mem_din;
            3'd2:    asm_q[15:8]  <= bus.mem_din;
            3'd3:    asm_q[23:16] <= bus.mem_din;
            default: ;
          endcase
          if (cnt_q < 3'd3) begin
            memA_q <= nextAddr_d;
          end
          if (cnt_q == 3'd4) begin
            inst_q  <= {bus.mem_din, asm_q};
            valid_q <= 1'b1;
            stall_q <= 1'b0;
            state_q <= FetchIdle;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= FetchIdle;
      endcase
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.stall_req  = stall_q;
  assign bus.mem_a      = memA_q;
  assign bus.mem_wr     = memWr_q;

endmodule
